clock_time_counter: RTL and testbench

- Time-of-day counter for the clock. Produces six BCD digits (HH:MM:SS, 24-hour format) that feed the per-digit 7-segment decoders directly.
- An internal prescaler derives a one-second tick from the system clock.
- A three-state mode machine lets the user set hours and minutes using two pulse inputs. Those inputs arrive already debounced and one-cycle wide from the button conditioning stage.

---
 rtl/clock_time_counter.sv | 166 ++++++++++++++++
 tb/tb_clock_time_counter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// 24-hour HH:MM:SS time-of-day counter with BCD digit outputs, a one-second
// prescaler and a RUN / SET_HOUR / SET_MIN mode machine for setting the time.
module clock_time_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_units,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [1:0] set_mode,
    output logic       sec_tick
);

    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_e;

    mode_e            state_q, state_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [3:0]       ht_q, ht_d, hu_q, hu_d;
    logic [3:0]       mt_q, mt_d, mu_q, mu_d;
    logic [3:0]       st_q, st_d, su_q, su_d;
    logic             sec_tick_q, sec_tick_d;

    logic             tick;
    logic [3:0]       ht_inc, hu_inc, mt_inc, mu_inc, st_inc, su_inc;
    logic             min_wrap, sec_wrap;

    // Per-field successors; the wrap flags drive the carry chain in RUN only.
    always_comb begin
        ht_inc   = ht_q;
        hu_inc   = hu_q + 4'd1;
        mt_inc   = mt_q;
        mu_inc   = mu_q + 4'd1;
        st_inc   = st_q;
        su_inc   = su_q + 4'd1;
        min_wrap = (mt_q == 4'd5) && (mu_q == 4'd9);
        sec_wrap = (st_q == 4'd5) && (su_q == 4'd9);

        if ((ht_q == 4'd2) && (hu_q == 4'd3)) begin
            ht_inc = 4'd0;
            hu_inc = 4'd0;
        end else if (hu_q == 4'd9) begin
            ht_inc = ht_q + 4'd1;
            hu_inc = 4'd0;
        end

        if (mu_q == 4'd9) begin
            mu_inc = 4'd0;
            mt_inc = (mt_q == 4'd5) ? 4'd0 : mt_q + 4'd1;
        end

        if (su_q == 4'd9) begin
            su_inc = 4'd0;
            st_inc = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
        end
    end

    assign tick = (state_q == RUN) && (pre_q == PRE_MAX);

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        ht_d       = ht_q;
        hu_d       = hu_q;
        mt_d       = mt_q;
        mu_d       = mu_q;
        st_d       = st_q;
        su_d       = su_q;
        sec_tick_d = 1'b0;

        case (state_q)
            RUN: begin
                pre_d      = tick ? '0 : pre_q + CNT_W'(1);
                sec_tick_d = tick;
                if (tick) begin
                    st_d = st_inc;
                    su_d = su_inc;
                    if (sec_wrap) begin
                        mt_d = mt_inc;
                        mu_d = mu_inc;
                        if (min_wrap) begin
                            ht_d = ht_inc;
                            hu_d = hu_inc;
                        end
                    end
                end
                // Clearing seconds on entry overrides the tick's seconds update,
                // but any minute/hour carry from the same tick is kept.
                if (mode_btn) begin
                    state_d = SET_HOUR;
                    st_d    = 4'd0;
                    su_d    = 4'd0;
                    pre_d   = '0;
                end
            end
            SET_HOUR: begin
                pre_d = '0;
                if (mode_btn) begin
                    state_d = SET_MIN;
                end else if (inc_btn) begin
                    ht_d = ht_inc;
                    hu_d = hu_inc;
                end
            end
            SET_MIN: begin
                pre_d = '0;
                if (mode_btn) begin
                    state_d = RUN;
                end else if (inc_btn) begin
                    mt_d = mt_inc;
                    mu_d = mu_inc;
                end
            end
            default: begin
                state_d = RUN;
                pre_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pre_q      <= '0;
            ht_q       <= 4'd0;
            hu_q       <= 4'd0;
            mt_q       <= 4'd0;
            mu_q       <= 4'd0;
            st_q       <= 4'd0;
            su_q       <= 4'd0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            ht_q       <= ht_d;
            hu_q       <= hu_d;
            mt_q       <= mt_d;
            mu_q       <= mu_d;
            st_q       <= st_d;
            su_q       <= su_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign hour_tens  = ht_q;
    assign hour_units = hu_q;
    assign min_tens   = mt_q;
    assign min_units  = mu_q;
    assign sec_tens   = st_q;
    assign sec_units  = su_q;
    assign set_mode   = state_q;
    assign sec_tick   = sec_tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with TICK_DIV=4; time is compared as a
// 24-bit packed BCD value so 24'h235959 reads as 23:59:59.
module tb_clock_time_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
    logic [1:0] set_mode;
    logic       sec_tick;

    int total = 0;
    int passed = 0;

    logic [23:0] now;
    assign now = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};

    clock_time_counter #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .hour_tens (hour_tens),
        .hour_units(hour_units),
        .min_tens  (min_tens),
        .min_units (min_units),
        .sec_tens  (sec_tens),
        .sec_units (sec_units),
        .set_mode  (set_mode),
        .sec_tick  (sec_tick)
    );

    always #5 clk = ~clk;

    // Drives one button pulse across a single rising edge; returns 1ns after it.
    task automatic press(input logic m, input logic i);
        @(negedge clk);
        mode_btn = m;
        inc_btn  = i;
        @(posedge clk);
        #1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic press_n_inc(input int n);
        repeat (n) press(1'b0, 1'b1);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if (now !== 24'h000000) $display("[TB] FAIL reset_time: got %h want 000000", now);
        else passed++;
        total++;
        if (set_mode !== 2'b00) $display("[TB] FAIL reset_mode: got %b want 00", set_mode);
        else passed++;
        total++;
        if (sec_tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b want 0", sec_tick);
        else passed++;
        run_cycles(3);
        total++;
        if (now !== 24'h000000 || sec_tick !== 1'b0)
            $display("[TB] FAIL reset_held: got %h/%b want 000000/0", now, sec_tick);
        else passed++;
    endtask

    task automatic test_run_40();
        logic exp_tick;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            exp_tick = (c % 4 == 0);
            total++;
            if (sec_tick !== exp_tick)
                $display("[TB] FAIL run_tick_c%0d: got %b want %b", c, sec_tick, exp_tick);
            else passed++;
            if (c == 36) begin
                total++;
                if (now !== 24'h000009) $display("[TB] FAIL run_time_36: got %h want 000009", now);
                else passed++;
            end
        end
        total++;
        if (now !== 24'h000010) $display("[TB] FAIL run_time_40: got %h want 000010", now);
        else passed++;
    endtask

    task automatic test_inc_ignored_in_run();
        press(1'b0, 1'b1);
        total++;
        if (now !== 24'h000010 || set_mode !== 2'b00)
            $display("[TB] FAIL run_inc_ignored: got %h/%b want 000010/00", now, set_mode);
        else passed++;
    endtask

    task automatic test_set_and_day_wrap();
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b01 || now !== 24'h000000)
            $display("[TB] FAIL enter_set_hour: got %b/%h want 01/000000", set_mode, now);
        else passed++;
        press_n_inc(23);
        total++;
        if (now !== 24'h230000) $display("[TB] FAIL set_hour_23: got %h want 230000", now);
        else passed++;
        press(1'b0, 1'b1);
        total++;
        if (now !== 24'h000000) $display("[TB] FAIL set_hour_wrap: got %h want 000000", now);
        else passed++;
        press_n_inc(23);
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b10) $display("[TB] FAIL enter_set_min: got %b want 10", set_mode);
        else passed++;
        press_n_inc(59);
        total++;
        if (now !== 24'h235900) $display("[TB] FAIL set_min_59: got %h want 235900", now);
        else passed++;
        press(1'b0, 1'b1);
        total++;
        if (now !== 24'h230000) $display("[TB] FAIL set_min_wrap: got %h want 230000", now);
        else passed++;
        press_n_inc(59);
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b00 || now !== 24'h235900 || sec_tick !== 1'b0)
            $display("[TB] FAIL back_to_run: got %b/%h/%b want 00/235900/0", set_mode, now, sec_tick);
        else passed++;
        run_cycles(236);
        total++;
        if (now !== 24'h235959 || sec_tick !== 1'b1)
            $display("[TB] FAIL reach_235959: got %h/%b want 235959/1", now, sec_tick);
        else passed++;
        run_cycles(3);
        total++;
        if (now !== 24'h235959 || sec_tick !== 1'b0)
            $display("[TB] FAIL hold_235959: got %h/%b want 235959/0", now, sec_tick);
        else passed++;
        run_cycles(1);
        total++;
        if (now !== 24'h000000 || sec_tick !== 1'b1)
            $display("[TB] FAIL day_wrap: got %h/%b want 000000/1", now, sec_tick);
        else passed++;
    endtask

    task automatic test_hour_carry();
        press(1'b1, 1'b0);
        press_n_inc(9);
        press(1'b1, 1'b0);
        press_n_inc(59);
        press(1'b1, 1'b0);
        run_cycles(236);
        total++;
        if (now !== 24'h095959) $display("[TB] FAIL reach_095959: got %h want 095959", now);
        else passed++;
        run_cycles(4);
        total++;
        if (now !== 24'h100000 || sec_tick !== 1'b1)
            $display("[TB] FAIL carry_09_10: got %h/%b want 100000/1", now, sec_tick);
        else passed++;
        press(1'b1, 1'b0);
        press_n_inc(9);
        press(1'b1, 1'b0);
        press_n_inc(59);
        press(1'b1, 1'b0);
        run_cycles(236);
        total++;
        if (now !== 24'h195959) $display("[TB] FAIL reach_195959: got %h want 195959", now);
        else passed++;
        run_cycles(4);
        total++;
        if (now !== 24'h200000 || sec_tick !== 1'b1)
            $display("[TB] FAIL carry_19_20: got %h/%b want 200000/1", now, sec_tick);
        else passed++;
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b0);
        press_n_inc(9);
        total++;
        if (now !== 24'h050000 || set_mode !== 2'b01)
            $display("[TB] FAIL hour_05: got %h/%b want 050000/01", now, set_mode);
        else passed++;
        press(1'b1, 1'b1);
        total++;
        if (now !== 24'h050000 || set_mode !== 2'b10)
            $display("[TB] FAIL mode_and_inc: got %h/%b want 050000/10", now, set_mode);
        else passed++;
    endtask

    task automatic test_mode_timing();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press_n_inc(7);
        press(1'b1, 1'b0);
        press_n_inc(34);
        press(1'b1, 1'b0);
        total++;
        if (now !== 24'h123400 || set_mode !== 2'b00)
            $display("[TB] FAIL preset_1234: got %h/%b want 123400/00", now, set_mode);
        else passed++;
        run_cycles(224);
        total++;
        if (now !== 24'h123456 || sec_tick !== 1'b1)
            $display("[TB] FAIL reach_123456: got %h/%b want 123456/1", now, sec_tick);
        else passed++;
        run_cycles(2);
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b01 || now !== 24'h123400 || sec_tick !== 1'b0)
            $display("[TB] FAIL enter_set_clear: got %b/%h/%b want 01/123400/0", set_mode, now, sec_tick);
        else passed++;
        for (int c = 0; c < 8; c++) begin
            run_cycles(1);
            total++;
            if (sec_tick !== 1'b0 || set_mode !== 2'b01)
                $display("[TB] FAIL hour_quiet_%0d: got %b/%b want 0/01", c, sec_tick, set_mode);
            else passed++;
        end
        press(1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            run_cycles(1);
            total++;
            if (sec_tick !== 1'b0 || set_mode !== 2'b10)
                $display("[TB] FAIL min_quiet_%0d: got %b/%b want 0/10", c, sec_tick, set_mode);
            else passed++;
        end
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b00 || sec_tick !== 1'b0)
            $display("[TB] FAIL exit_to_run: got %b/%b want 00/0", set_mode, sec_tick);
        else passed++;
        for (int c = 1; c <= 4; c++) begin
            logic exp_tick;
            run_cycles(1);
            exp_tick = (c == 4);
            total++;
            if (sec_tick !== exp_tick)
                $display("[TB] FAIL first_tick_c%0d: got %b want %b", c, sec_tick, exp_tick);
            else passed++;
        end
        total++;
        if (now !== 24'h123401) $display("[TB] FAIL after_first_tick: got %h want 123401", now);
        else passed++;
    endtask

    task automatic test_reset_mid();
        press(1'b1, 1'b0);
        press_n_inc(19);
        press(1'b1, 1'b0);
        press_n_inc(34);
        total++;
        if (now !== 24'h070800 || set_mode !== 2'b10)
            $display("[TB] FAIL preset_0708: got %h/%b want 070800/10", now, set_mode);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (now !== 24'h000000 || set_mode !== 2'b00 || sec_tick !== 1'b0)
            $display("[TB] FAIL async_reset: got %h/%b/%b want 000000/00/0", now, set_mode, sec_tick);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(4);
        total++;
        if (now !== 24'h000001 || sec_tick !== 1'b1)
            $display("[TB] FAIL restart_after_reset: got %h/%b want 000001/1", now, sec_tick);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_run_40();
        test_inc_ignored_in_run();
        test_set_and_day_wrap();
        test_hour_carry();
        test_simultaneous();
        test_mode_timing();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
